// File: rtl/fmlbrg_datamem.sv
// fmlbrg_datamem
// Data store of the FML bridge cache: a single-port synchronous SRAM of
// 2^depth 32-bit words, built from four independent 8-bit lanes so that
// Wishbone byte-masked writes and FML full-word refills share one array.
// Reads are registered and write-first per lane, so a written byte appears
// on dout after the same edge. The bridge uses this to ack a read miss in
// the cycle after the critical word lands.
// Because "do" is a reserved word in SystemVerilog, the read-data port is
// named dout.
module fmlbrg_datamem #(
    parameter int depth = 11
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [depth-1:0] a,
    input  logic [3:0]       we,
    input  logic [31:0]      di,
    output logic [31:0]      dout
);

    localparam int WORDS = 1 << depth;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // One block-RAM-inferable array per byte lane. The initialiser
            // only gives simulation a defined power-up state; reset never
            // touches the contents.
            logic [7:0] lane_mem [0:WORDS-1] = '{default: 8'h00};
            logic [7:0] rd_reg;

            // Lane write: suppressed while reset is held so the memory is
            // preserved across reset.
            always_ff @(posedge sys_clk) begin
                if (!sys_rst && we[gi]) begin
                    lane_mem[a] <= di[8*gi +: 8];
                end
            end

            // Registered lane read, write-first, cleared asynchronously.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    rd_reg <= 8'h00;
                end else if (we[gi]) begin
                    rd_reg <= di[8*gi +: 8];
                end else begin
                    rd_reg <= lane_mem[a];
                end
            end

            assign dout[8*gi +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fmlbrg_datamem.sv
// tb_fmlbrg_datamem
// Scoreboard bench for fmlbrg_datamem. The stimulus process applies one
// transaction per clock, works out the expected read data from a plain
// word-array model and pushes it into a queue; the monitor pops one entry
// after every rising edge and compares it with dout.
module tb_fmlbrg_datamem;

    localparam int DEPTH = 11;
    localparam int WORDS = 1 << DEPTH;

    logic             sys_clk;
    logic             sys_rst;
    logic [DEPTH-1:0] a;
    logic [3:0]       we;
    logic [31:0]      di;
    logic [31:0]      dout;

    typedef struct {
        logic [31:0]      exp;
        logic [DEPTH-1:0] addr;
        logic [3:0]       wen;
        logic             rst;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    logic [31:0] model_mem [0:WORDS-1];
    int          checks   = 0;
    int          failures = 0;
    int          txn_no   = 0;

    fmlbrg_datamem #(.depth(DEPTH)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .a       (a),
        .we      (we),
        .di      (di),
        .dout    (dout)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Apply one transaction at the falling edge; record the response the
    // next rising edge must produce and update the model to post-edge state.
    task automatic drive(input logic [DEPTH-1:0] ta, input logic [3:0] twe,
                         input logic [31:0] tdi, input logic trst);
        sb_entry_t e;
        logic [31:0] old_word;
        @(negedge sys_clk);
        a       = ta;
        we      = twe;
        di      = tdi;
        sys_rst = trst;
        old_word = model_mem[ta];
        e.addr = ta;
        e.wen  = twe;
        e.rst  = trst;
        if (trst) begin
            e.exp = 32'h0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                e.exp[8*b +: 8] = twe[b] ? tdi[8*b +: 8] : old_word[8*b +: 8];
            end
            model_mem[ta] = e.exp;
        end
        sb_q.push_back(e);
    endtask

    // Monitor: one comparison per rising edge that has a pending entry.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txn_no++;
                $display("txn %0d a=%h we=%h rst=%0d dout=%h exp=%h",
                         txn_no, e.addr, e.wen, e.rst, dout, e.exp);
                check($sformatf("read a=%0h", e.addr), dout, e.exp);
            end
        end
    end

    initial begin
        logic [DEPTH-1:0] ra;
        logic [3:0]       rwe;
        for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;

        // Reset held for two edges with a full write pending at a=0.
        sys_rst = 1'b1;
        a       = '0;
        we      = 4'hF;
        di      = 32'hFFFF_FFFF;
        #2;
        check("reset dout", dout, 32'h0);
        drive('0, 4'hF, 32'hFFFF_FFFF, 1'b1);
        drive('0, 4'hF, 32'hFFFF_FFFF, 1'b1);
        drive('0, 4'h0, 32'h0, 1'b0);

        // Full write then readback.
        drive(11'd5, 4'hF, 32'hDEAD_BEEF, 1'b0);
        drive(11'd5, 4'h0, 32'h0, 1'b0);

        // Single-lane merge.
        drive(11'd5, 4'b0010, 32'h0000_AA00, 1'b0);
        drive(11'd5, 4'h0, 32'h0, 1'b0);
        drive(11'd5, 4'b0101, 32'h1122_3344, 1'b0);
        drive(11'd5, 4'h0, 32'h0, 1'b0);

        // Burst fill then out-of-order reads.
        drive(11'd8,  4'hF, 32'h1111_1111, 1'b0);
        drive(11'd9,  4'hF, 32'h2222_2222, 1'b0);
        drive(11'd10, 4'hF, 32'h3333_3333, 1'b0);
        drive(11'd11, 4'hF, 32'h4444_4444, 1'b0);
        drive(11'd10, 4'h0, 32'h0, 1'b0);
        drive(11'd8,  4'h0, 32'h0, 1'b0);
        drive(11'd11, 4'h0, 32'h0, 1'b0);
        drive(11'd9,  4'h0, 32'h0, 1'b0);
        drive(11'd11, 4'h0, 32'h0, 1'b0);

        // Asynchronous reset pulse between edges while dout holds 44444444.
        @(negedge sys_clk);
        check("pre-pulse dout", dout, 32'h4444_4444);
        sys_rst = 1'b1;
        #1;
        check("async clear dout", dout, 32'h0);
        #1;
        sys_rst = 1'b0;
        drive(11'd11, 4'h0, 32'h0, 1'b0);

        // Top address, no aliasing onto address 0.
        drive(11'(WORDS - 1), 4'hF, 32'hA5A5_A5A5, 1'b0);
        drive('0, 4'h0, 32'h0, 1'b0);
        drive(11'(WORDS - 1), 4'h0, 32'h0, 1'b0);

        // Randomised traffic, including occasional whole-cycle resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) ra = 11'($urandom_range(0, WORDS - 1));
            else if ($urandom_range(0, 1) == 0) ra = 11'($urandom_range(0, 15));
            else ra = 11'(WORDS - 1 - $urandom_range(0, 3));
            rwe = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            drive(ra, rwe, $urandom, ($urandom_range(0, 19) == 0));
        end
        drive('0, 4'h0, 32'h0, 1'b0);

        @(posedge sys_clk);
        #3;
        check("scoreboard drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
